key_debounce: RTL

- Four-channel pushbutton conditioner that sits directly upstream of the 128-bit key-pattern generator.
- Takes raw, asynchronous, active-low board buttons and produces the clean, active-high, level-stable 4-bit `key_bus` that the generator samples.
- Also produces per-channel one-cycle press and release pulses, plus an aggregate event pulse, for control logic.

---
 rtl/key_debounce.sv | 116 +++++++++++
 1 files changed

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Purpose  : Four-channel pushbutton conditioner. It synchronises raw,
//            asynchronous, active-low buttons and accepts a new level only
//            after CNT_MAX consecutive stable cycles. The result is a clean,
//            active-high level bus plus one-cycle press/release/event pulses.
// Ports    : sclk        - system clock, rising edge
//            rst         - asynchronous reset, active high
//            key_in      - raw button pins (0 = pressed)
//            key_bus     - debounced level (1 = pressed)
//            key_press   - one-cycle pulse on accepted released->pressed
//            key_release - one-cycle pulse on accepted pressed->released
//            key_event   - one-cycle OR of all press/release pulses
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int N_KEYS  = 4,
    parameter int CNT_MAX = 1000000,
    parameter int CNT_W   = 20
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_bus,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic              key_event
);

    // Terminal count: the change is accepted on the cycle the counter sits here
    // and the input still differs, i.e. after CNT_MAX differing samples.
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(CNT_MAX - 1);

    // Two-flop synchroniser; reset to "released" so no spurious press appears.
    logic [N_KEYS-1:0] r_s1;
    logic [N_KEYS-1:0] r_s2;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_s1 <= '1;
            r_s2 <= '1;
        end else begin
            r_s1 <= key_in;
            r_s2 <= r_s1;
        end
    end

    logic [N_KEYS-1:0] w_press_nxt;
    logic [N_KEYS-1:0] w_release_nxt;
    logic [N_KEYS-1:0] w_level;
    logic [N_KEYS-1:0] w_press;
    logic [N_KEYS-1:0] w_release;

    generate
        for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
            logic [CNT_W-1:0] r_cnt;
            logic             r_level;
            logic             r_press;
            logic             r_release;
            logic             w_diff;
            logic             w_fire;

            // Synchronised pin is active low; the debounced level is active high.
            assign w_diff = (~r_s2[i]) != r_level;
            assign w_fire = w_diff && (r_cnt == c_CNT_LAST);

            assign w_press_nxt[i]   = w_fire & ~r_s2[i];
            assign w_release_nxt[i] = w_fire &  r_s2[i];

            always_ff @(posedge sclk or posedge rst) begin
                if (rst) begin
                    r_cnt     <= '0;
                    r_level   <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                end else begin
                    r_press   <= w_press_nxt[i];
                    r_release <= w_release_nxt[i];
                    if (!w_diff) begin
                        // Any agreeing cycle discards all accumulated credit.
                        r_cnt <= '0;
                    end else if (w_fire) begin
                        r_cnt   <= '0;
                        r_level <= ~r_s2[i];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_level[i]   = r_level;
            assign w_press[i]   = r_press;
            assign w_release[i] = r_release;
        end
    endgenerate

    // Event is registered from the same next-state terms as the per-channel
    // pulses so all pulses line up with the key_bus update.
    logic r_event;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_event <= 1'b0;
        end else begin
            r_event <= |(w_press_nxt | w_release_nxt);
        end
    end

    assign key_bus     = w_level;
    assign key_press   = w_press;
    assign key_release = w_release;
    assign key_event   = r_event;

endmodule
`default_nettype wire
